// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell, time-shared by the serial add controller.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half;

    always_comb begin
        half = a ^ b;
        sum  = half ^ cin;
        cout = (a & b) | (cin & half);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds two WIDTH-bit operands LSB-first through one full-adder cell, one bit per clock,
// behind a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // The bit shifted out of the low end is never needed, so this stops one short of WIDTH;
    // the final cell output completes the word directly into sum.
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_word;
    logic             carry;
    logic             cell_sum;
    logic             cell_cout;
    logic             accept;
    logic             last_bit;

    full_adder_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        last_bit = (state == RUN) && (count == CNT_W'(WIDTH - 1));
        sum_word = {cell_sum, sum_sh};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= cell_cout;
            sum_sh <= sum_word[WIDTH-1:1];
            if (last_bit) begin
                count <= '0;
                sum   <= sum_word;
                cout  <= cell_cout;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
